// File: rtl/dispense_controller_if.sv
// Keypad, button, flow-sensor and valve signals of the dispense controller.
// master = the controller itself; slave = the surrounding keypad/sensor/valve side.
interface dispense_controller_if #(
  parameter int AMOUNT_WIDTH = 14
);
  logic [AMOUNT_WIDTH-1:0] target_amount;
  logic                    ok_pressed;
  logic                    cancel_pressed;
  logic                    flow_pulse;
  logic                    valve_open;
  logic                    busy;
  logic                    done;
  logic                    fault;
  logic [AMOUNT_WIDTH-1:0] dispensed_amount;
  logic                    clear_entry;

  modport master (
    input  target_amount, ok_pressed, cancel_pressed, flow_pulse,
    output valve_open, busy, done, fault, dispensed_amount, clear_entry
  );

  modport slave (
    output target_amount, ok_pressed, cancel_pressed, flow_pulse,
    input  valve_open, busy, done, fault, dispensed_amount, clear_entry
  );
endinterface

// File: rtl/dispense_controller.sv
// Latches a confirmed volume, opens the valve and counts flow pulses to the target.
// Outputs registered, one clock after the deciding input; flow count lands 3 clocks after a sensor edge.
module dispense_controller #(
  parameter int AMOUNT_WIDTH     = 14,
  parameter int MAX_AMOUNT       = 9999,
  parameter int ML_PER_PULSE     = 5,
  parameter int TIMEOUT_CYCLES   = 50000000,
  parameter int DONE_HOLD_CYCLES = 100000000
) (
  input logic                  clock,
  input logic                  reset,
  dispense_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE, DISPENSING, DONE, FAULT} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (DONE_HOLD_CYCLES > 1) ? $clog2(DONE_HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]           TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0]           HOLD_LAST = HW'(DONE_HOLD_CYCLES - 1);
  localparam logic [AMOUNT_WIDTH-1:0] MAX_AMT   = AMOUNT_WIDTH'(MAX_AMOUNT);
  localparam logic [AMOUNT_WIDTH:0]   STEP      = (AMOUNT_WIDTH + 1)'(ML_PER_PULSE);

  state_t                  state, state_nxt;
  logic [AMOUNT_WIDTH-1:0] target, target_nxt;
  logic [AMOUNT_WIDTH-1:0] amount, amount_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic [HW-1:0]           hold, hold_nxt;
  logic                    clear_nxt;
  logic                    flow_meta, flow_sync, flow_prev;
  logic                    flow_edge;
  logic                    target_ok;
  logic [AMOUNT_WIDTH:0]   sum_raw;
  logic [AMOUNT_WIDTH-1:0] sum_sat;

  assign flow_edge = flow_sync & ~flow_prev;
  assign target_ok = (bus.target_amount != '0) && (bus.target_amount <= MAX_AMT);
  assign sum_raw   = {1'b0, amount} + STEP;
  assign sum_sat   = sum_raw[AMOUNT_WIDTH] ? '1 : sum_raw[AMOUNT_WIDTH-1:0];

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    amount_nxt = amount;
    timer_nxt  = timer;
    hold_nxt   = hold;
    clear_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cancel_pressed) begin
          clear_nxt = 1'b1;
        end else if (bus.ok_pressed && target_ok) begin
          target_nxt = bus.target_amount;
          amount_nxt = '0;
          timer_nxt  = '0;
          clear_nxt  = 1'b1;
          state_nxt  = DISPENSING;
        end
      end
      DISPENSING: begin
        // Cancel beats a same-cycle flow edge, which is dropped.
        if (bus.cancel_pressed) begin
          hold_nxt  = '0;
          state_nxt = DONE;
        end else if (flow_edge) begin
          amount_nxt = sum_sat;
          timer_nxt  = '0;
          if (sum_sat >= target) begin
            hold_nxt  = '0;
            state_nxt = DONE;
          end
        end else if (timer == TMR_LAST) begin
          state_nxt = FAULT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DONE: begin
        if (bus.cancel_pressed || hold == HOLD_LAST) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold + 1'b1;
        end
      end
      FAULT: begin
        if (bus.cancel_pressed) begin
          clear_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state, so valve_open tracks busy exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      target               <= '0;
      amount               <= '0;
      timer                <= '0;
      hold                 <= '0;
      flow_meta            <= 1'b0;
      flow_sync            <= 1'b0;
      flow_prev            <= 1'b0;
      bus.valve_open       <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.fault            <= 1'b0;
      bus.clear_entry      <= 1'b0;
      bus.dispensed_amount <= '0;
    end else begin
      state                <= state_nxt;
      target               <= target_nxt;
      amount               <= amount_nxt;
      timer                <= timer_nxt;
      hold                 <= hold_nxt;
      flow_meta            <= bus.flow_pulse;
      flow_sync            <= flow_meta;
      flow_prev            <= flow_sync;
      bus.valve_open       <= (state_nxt == DISPENSING);
      bus.busy             <= (state_nxt == DISPENSING);
      bus.done             <= (state_nxt == DONE);
      bus.fault            <= (state_nxt == FAULT);
      bus.clear_entry      <= clear_nxt;
      bus.dispensed_amount <= amount_nxt;
    end
  end
endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller with short timeout/hold parameters.
module tb_dispense_controller;
  logic clock;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  dispense_controller_if #(.AMOUNT_WIDTH(14)) bus ();

  dispense_controller #(
    .AMOUNT_WIDTH(14), .MAX_AMOUNT(9999), .ML_PER_PULSE(5),
    .TIMEOUT_CYCLES(20), .DONE_HOLD_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {valve_open, busy, done, fault, clear_entry}
  function automatic logic [4:0] outs();
    return {bus.valve_open, bus.busy, bus.done, bus.fault, bus.clear_entry};
  endfunction

  task automatic flow_edge();
    bus.flow_pulse = 1'b1;
    tick();
    tick();
    bus.flow_pulse = 1'b0;
    tick();
  endtask

  task automatic press_ok(input logic [13:0] amt);
    bus.target_amount = amt;
    bus.ok_pressed = 1'b1;
    tick();
    bus.ok_pressed = 1'b0;
  endtask

  task automatic press_cancel();
    bus.cancel_pressed = 1'b1;
    tick();
    bus.cancel_pressed = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.target_amount = '0;
    bus.ok_pressed = 1'b0;
    bus.cancel_pressed = 1'b0;
    bus.flow_pulse = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL reset_outs: got %b want 00000", outs()); end
    checks++;
    if (bus.dispensed_amount !== 14'd0) begin fails++; $display("FAIL reset_amount: got %0d want 0", bus.dispensed_amount); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    press_ok(14'd25);
    checks++;
    if (outs() !== 5'b11001) begin fails++; $display("FAIL normal_accept: got %b want 11001", outs()); end
    checks++;
    if (bus.dispensed_amount !== 14'd0) begin fails++; $display("FAIL normal_amount0: got %0d want 0", bus.dispensed_amount); end
    tick();
    checks++;
    if (outs() !== 5'b11000) begin fails++; $display("FAIL normal_clear_one_cycle: got %b want 11000", outs()); end
    for (int i = 1; i <= 5; i++) begin
      flow_edge();
      checks++;
      if (bus.dispensed_amount !== 14'(5 * i)) begin
        fails++; $display("FAIL normal_count%0d: got %0d want %0d", i, bus.dispensed_amount, 5 * i);
      end
      if (i < 5) begin
        checks++;
        if (outs() !== 5'b11000) begin fails++; $display("FAIL normal_open%0d: got %b want 11000", i, outs()); end
        repeat (3) tick();
      end
    end
    checks++;
    if (outs() !== 5'b00100) begin fails++; $display("FAIL normal_done: got %b want 00100", outs()); end
    repeat (3) tick();
    checks++;
    if (outs() !== 5'b00100) begin fails++; $display("FAIL normal_hold3: got %b want 00100", outs()); end
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL normal_idle: got %b want 00000", outs()); end
    checks++;
    if (bus.dispensed_amount !== 14'd25) begin fails++; $display("FAIL normal_kept: got %0d want 25", bus.dispensed_amount); end
  endtask

  task automatic test_overshoot();
    press_ok(14'd12);
    checks++;
    if (outs() !== 5'b11001) begin fails++; $display("FAIL over_accept: got %b want 11001", outs()); end
    tick();
    flow_edge();
    flow_edge();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b11000, 14'd10}) begin
      fails++; $display("FAIL over_mid: got %b/%0d want 11000/10", outs(), bus.dispensed_amount);
    end
    flow_edge();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00100, 14'd15}) begin
      fails++; $display("FAIL over_done: got %b/%0d want 00100/15", outs(), bus.dispensed_amount);
    end
    repeat (4) tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL over_idle: got %b want 00000", outs()); end
  endtask

  task automatic test_range();
    press_ok(14'd0);
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00000, 14'd15}) begin
      fails++; $display("FAIL range_zero: got %b/%0d want 00000/15", outs(), bus.dispensed_amount);
    end
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL range_zero_late: got %b want 00000", outs()); end
    press_ok(14'd10000);
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL range_10000: got %b want 00000", outs()); end
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL range_10000_late: got %b want 00000", outs()); end
    bus.target_amount = 14'd50;
    bus.ok_pressed = 1'b1;
    bus.cancel_pressed = 1'b1;
    tick();
    bus.ok_pressed = 1'b0;
    bus.cancel_pressed = 1'b0;
    checks++;
    if (outs() !== 5'b00001) begin fails++; $display("FAIL range_ok_cancel: got %b want 00001", outs()); end
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL range_ok_cancel_after: got %b want 00000", outs()); end
  endtask

  task automatic test_cancel();
    press_ok(14'd100);
    tick();
    repeat (4) flow_edge();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b11000, 14'd20}) begin
      fails++; $display("FAIL cancel_before: got %b/%0d want 11000/20", outs(), bus.dispensed_amount);
    end
    bus.target_amount = 14'd3;
    press_cancel();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00100, 14'd20}) begin
      fails++; $display("FAIL cancel_done: got %b/%0d want 00100/20", outs(), bus.dispensed_amount);
    end
    press_cancel();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00000, 14'd20}) begin
      fails++; $display("FAIL cancel_from_done: got %b/%0d want 00000/20", outs(), bus.dispensed_amount);
    end
  endtask

  task automatic test_reset_mid();
    press_ok(14'd100);
    flow_edge();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b11000, 14'd5}) begin
      fails++; $display("FAIL rmid_before: got %b/%0d want 11000/5", outs(), bus.dispensed_amount);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00000, 14'd0}) begin
      fails++; $display("FAIL rmid_async: got %b/%0d want 00000/0", outs(), bus.dispensed_amount);
    end
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL rmid_after: got %b want 00000", outs()); end
  endtask

  task automatic test_timeout();
    press_ok(14'd100);
    flow_edge();
    flow_edge();
    repeat (19) tick();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b11000, 14'd10}) begin
      fails++; $display("FAIL tmo_19: got %b/%0d want 11000/10", outs(), bus.dispensed_amount);
    end
    tick();
    checks++;
    if (outs() !== 5'b00010) begin fails++; $display("FAIL tmo_fault: got %b want 00010", outs()); end
    press_ok(14'd50);
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00010, 14'd10}) begin
      fails++; $display("FAIL tmo_ok_ignored: got %b/%0d want 00010/10", outs(), bus.dispensed_amount);
    end
    flow_edge();
    checks++;
    if ({outs(), bus.dispensed_amount} !== {5'b00010, 14'd10}) begin
      fails++; $display("FAIL tmo_flow_ignored: got %b/%0d want 00010/10", outs(), bus.dispensed_amount);
    end
    press_cancel();
    checks++;
    if (outs() !== 5'b00001) begin fails++; $display("FAIL tmo_cancel: got %b want 00001", outs()); end
    tick();
    checks++;
    if (outs() !== 5'b00000) begin fails++; $display("FAIL tmo_idle: got %b want 00000", outs()); end
  endtask

  task automatic test_stuck_high();
    press_ok(14'd100);
    bus.flow_pulse = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 3) begin
        checks++;
        if (bus.dispensed_amount !== 14'd5) begin fails++; $display("FAIL stuck_first: got %0d want 5", bus.dispensed_amount); end
      end
      if (k == 22) begin
        checks++;
        if (outs() !== 5'b11000) begin fails++; $display("FAIL stuck_22: got %b want 11000", outs()); end
      end
      if (k == 23) begin
        checks++;
        if (outs() !== 5'b00010) begin fails++; $display("FAIL stuck_fault: got %b want 00010", outs()); end
      end
    end
    checks++;
    if (bus.dispensed_amount !== 14'd5) begin fails++; $display("FAIL stuck_total: got %0d want 5", bus.dispensed_amount); end
    bus.flow_pulse = 1'b0;
    repeat (3) tick();
    press_cancel();
    checks++;
    if (outs() !== 5'b00001) begin fails++; $display("FAIL stuck_cancel: got %b want 00001", outs()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overshoot();
    test_range();
    test_cancel();
    test_reset_mid();
    test_timeout();
    test_stuck_high();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dispense_controller.md
Name: dispense_controller

Overview:
- Sequences a dispense once the keypad entry block has produced a requested volume (0..9999 mL).
- Latches the target on a confirm pulse and opens the valve.
- Counts flow-meter pulses until the target is reached, then closes the valve and reports completion.
- Sits between the keypad entry block, the debounced confirm/cancel buttons, the flow sensor and the valve driver.

Parameters:
- AMOUNT_WIDTH, 14, width of amount buses (covers 9999)
- MAX_AMOUNT, 9999, largest accepted target in mL
- ML_PER_PULSE, 5, mL represented by one flow-meter pulse
- TIMEOUT_CYCLES, 50000000, clocks without a flow pulse while dispensing before fault
- DONE_HOLD_CYCLES, 100000000, clocks the done indication is held before returning to idle

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- target_amount  input  AMOUNT_WIDTH  requested volume in mL from the keypad entry block
- ok_pressed  input  1  one-cycle pulse, confirm button released
- cancel_pressed  input  1  one-cycle pulse, cancel button released
- flow_pulse  input  1  raw flow-meter output, asynchronous to clock
- valve_open  output  1  1 = valve driven open
- busy  output  1  1 while in DISPENSING
- done  output  1  1 while in DONE
- fault  output  1  1 while in FAULT
- dispensed_amount  output  AMOUNT_WIDTH  mL counted in the current or last dispense
- clear_entry  output  1  one-cycle pulse telling the keypad entry block to clear

Behaviour:
- Reset, asynchronous:
  - state IDLE.
  - valve_open, busy, done, fault, clear_entry = 0.
  - dispensed_amount = 0; latched target = 0; timers = 0.
  - Flow synchroniser flops = 0.
  - The valve must close immediately, including mid-dispense.
- flow_pulse path: two-flop synchroniser, then rising-edge detect. A sensor rising edge registers as a count 3 clocks later. Level-high or level-low produces no counts.
- All outputs are registered. valve_open == busy at all times.
- IDLE:
  - ok_pressed with 1 <= target_amount <= MAX_AMOUNT and no cancel_pressed in the same cycle:
    - latch target; dispensed_amount <= 0; timeout timer <= 0.
    - clear_entry pulses 1 for exactly one cycle.
    - next state DISPENSING, so valve_open = 1 one clock after the ok cycle.
  - ok_pressed with target 0 or > MAX_AMOUNT: ignored, stay IDLE, no clear_entry.
  - cancel_pressed alone: clear_entry pulse, stay IDLE.
  - Cancel wins over simultaneous ok.
- DISPENSING:
  - Each detected flow edge:
    - dispensed_amount += ML_PER_PULSE, saturating at 2^AMOUNT_WIDTH-1.
    - timeout timer <= 0.
  - Once dispensed_amount (after the add) >= latched target: next state DONE.
    - Valve closes on that clock edge.
    - Overshoot up to ML_PER_PULSE-1 is allowed and shown.
  - cancel_pressed: next state DONE with the partial dispensed_amount. Cancel has priority over a same-cycle flow edge; that edge is not counted.
  - No flow edge for TIMEOUT_CYCLES consecutive clocks: next state FAULT.
  - ok_pressed is ignored; target_amount changes are ignored (target is latched).
- DONE:
  - done = 1; dispensed_amount frozen.
  - Hold counter counts DONE_HOLD_CYCLES, then next state IDLE. dispensed_amount keeps its value until the next accepted ok.
  - cancel_pressed: return to IDLE immediately.
  - ok_pressed is ignored.
  - Flow edges (drip-through) are ignored.
- FAULT:
  - fault = 1, valve closed, dispensed_amount frozen.
  - Only cancel_pressed exits, to IDLE with a clear_entry pulse.
  - ok_pressed and flow edges are ignored.
- Exactly one of busy/done/fault is high, or none in IDLE.
- Counters are sized with $clog2 of their parameter and must not wrap.

Test Plan:
(bench uses ML_PER_PULSE=5, TIMEOUT_CYCLES=20, DONE_HOLD_CYCLES=4)
- target 25, ok pulse, then 5 flow edges spaced 6 clocks apart:
  - valve_open high 1 clock after ok; clear_entry high 1 cycle.
  - After the 5th edge plus 3 clocks: dispensed_amount=25, valve_open=0, done=1.
  - done held 4 clocks, then IDLE.
- target 12, ok, 3 flow edges -> valve closes with dispensed_amount=15 (overshoot), done=1.
- Target-range checks:
  - target 0, ok -> no response: valve_open=0, clear_entry=0.
  - target 10000, ok -> same, no response.
  - ok and cancel in the same cycle with target 50 -> clear_entry only, valve stays closed.
- Mid-dispense events (target 100):
  - Cancel after 4 edges -> valve closes next clock, done=1, dispensed_amount=20.
  - Separately, assert reset mid-dispense -> valve_open=0 with no clock edge, all outputs 0.
- target 100, ok, 2 edges then no flow:
  - 20 clocks after the last count, fault=1 and valve_open=0.
  - ok is ignored while faulted.
  - cancel -> IDLE, fault=0, clear_entry pulse.
- Hold flow_pulse high 30 clocks during a dispense -> exactly one count, then timeout fault.
